// File: rtl/mod_exp_engine_if.sv
// Request/response bundle for the modular exponentiator: operands and start in,
// status flags and result out.
interface mod_exp_engine_if #(
    parameter int WIDTH     = 64,
    parameter int EXP_WIDTH = 64
);
    logic                 start;
    logic [WIDTH-1:0]     base;
    logic [EXP_WIDTH-1:0] exponent;
    logic [WIDTH-1:0]     modulus;
    logic                 busy;
    logic                 isDone;
    logic [WIDTH-1:0]     result;
    logic                 error;

    modport master (
        output start, base, exponent, modulus,
        input  busy, isDone, result, error
    );

    modport slave (
        input  start, base, exponent, modulus,
        output busy, isDone, result, error
    );
endinterface

// File: rtl/mod_exp_engine.sv
// Bit-serial modular exponentiator: result = base^exponent mod modulus using one
// shift-add modular multiplier shared by base reduction, squaring and multiplication.
//
// state    | meaning
// ---------+-----------------------------------------------------------------
// S_IDLE   | waiting for start after reset
// S_CHECK  | reject modulus 0, seed acc with 1 mod n
// S_REDUCE | b = base mod n, one base bit per cycle
// S_SQUARE | acc = acc*acc mod n, one multiplier bit per cycle
// S_MULT   | acc = acc*b mod n, one multiplier bit per cycle
// S_FINISH | publish result / error, drop busy
// S_DONE   | result held until the next start
module mod_exp_engine #(
    parameter int WIDTH     = 64,
    parameter int EXP_WIDTH = 64
) (
    input logic            clk,
    input logic            reset,
    mod_exp_engine_if.slave bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int KW = (EXP_WIDTH > 1) ? $clog2(EXP_WIDTH) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH - 1);
    localparam logic [KW-1:0] K_MAX   = KW'(EXP_WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_CHECK, S_REDUCE, S_SQUARE, S_MULT, S_FINISH, S_DONE
    } state_t;

    state_t               state_q, state_d;
    logic [WIDTH-1:0]     base_q, base_d;
    logic [EXP_WIDTH-1:0] exp_q, exp_d;
    logic [WIDTH-1:0]     mod_q, mod_d;
    logic [WIDTH-1:0]     acc_q, acc_d;
    logic [WIDTH-1:0]     b_q, b_d;
    logic [WIDTH-1:0]     mm_q, mm_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [KW-1:0]        k_q, k_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 error_q, error_d;
    logic [WIDTH-1:0]     result_q, result_d;

    logic [WIDTH:0]       n_ext;
    logic [WIDTH:0]       dbl;
    logic [WIDTH-1:0]     red1;
    logic [WIDTH:0]       sum;
    logic [WIDTH-1:0]     red2;
    logic [WIDTH-1:0]     mul_y;
    logic [WIDTH-1:0]     step;
    logic                 in_bit;
    logic                 last;

    always_comb begin
        state_d  = state_q;
        base_d   = base_q;
        exp_d    = exp_q;
        mod_d    = mod_q;
        acc_d    = acc_q;
        b_d      = b_q;
        mm_d     = mm_q;
        cnt_d    = cnt_q;
        k_d      = k_q;
        busy_d   = busy_q;
        done_d   = done_q;
        error_d  = error_q;
        result_d = result_q;

        // Shared step: both running values stay below n, so WIDTH+1 bits never overflow.
        n_ext  = {1'b0, mod_q};
        in_bit = (state_q == S_REDUCE) ? base_q[cnt_q] : 1'b0;
        dbl    = {mm_q, in_bit};
        red1   = (dbl >= n_ext) ? WIDTH'(dbl - n_ext) : WIDTH'(dbl);
        sum    = {1'b0, red1} + {1'b0, acc_q};
        red2   = (sum >= n_ext) ? WIDTH'(sum - n_ext) : WIDTH'(sum);
        mul_y  = (state_q == S_MULT) ? b_q : acc_q;
        step   = ((state_q != S_REDUCE) && mul_y[cnt_q]) ? red2 : red1;
        last   = (cnt_q == '0);

        case (state_q)
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    base_d   = bus.base;
                    exp_d    = bus.exponent;
                    mod_d    = bus.modulus;
                    done_d   = 1'b0;
                    error_d  = 1'b0;
                    result_d = '0;
                    busy_d   = 1'b1;
                    state_d  = S_CHECK;
                end
            end
            S_CHECK: begin
                if (mod_q == '0) begin
                    acc_d   = '0;
                    state_d = S_FINISH;
                end else begin
                    acc_d   = (mod_q == WIDTH'(1)) ? '0 : WIDTH'(1);
                    mm_d    = '0;
                    cnt_d   = CNT_MAX;
                    k_d     = K_MAX;
                    state_d = S_REDUCE;
                end
            end
            S_REDUCE: begin
                mm_d  = step;
                cnt_d = cnt_q - 1'b1;
                if (last) begin
                    b_d     = step;
                    mm_d    = '0;
                    cnt_d   = CNT_MAX;
                    state_d = S_SQUARE;
                end
            end
            S_SQUARE: begin
                mm_d  = step;
                cnt_d = cnt_q - 1'b1;
                if (last) begin
                    acc_d = step;
                    mm_d  = '0;
                    cnt_d = CNT_MAX;
                    if (exp_q[k_q]) begin
                        state_d = S_MULT;
                    end else if (k_q == '0) begin
                        state_d = S_FINISH;
                    end else begin
                        k_d     = k_q - 1'b1;
                        state_d = S_SQUARE;
                    end
                end
            end
            S_MULT: begin
                mm_d  = step;
                cnt_d = cnt_q - 1'b1;
                if (last) begin
                    acc_d = step;
                    mm_d  = '0;
                    cnt_d = CNT_MAX;
                    if (k_q == '0) begin
                        state_d = S_FINISH;
                    end else begin
                        k_d     = k_q - 1'b1;
                        state_d = S_SQUARE;
                    end
                end
            end
            S_FINISH: begin
                result_d = acc_q;
                done_d   = 1'b1;
                busy_d   = 1'b0;
                error_d  = (mod_q == '0);
                state_d  = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            base_q   <= '0;
            exp_q    <= '0;
            mod_q    <= '0;
            acc_q    <= '0;
            b_q      <= '0;
            mm_q     <= '0;
            cnt_q    <= '0;
            k_q      <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            error_q  <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            base_q   <= base_d;
            exp_q    <= exp_d;
            mod_q    <= mod_d;
            acc_q    <= acc_d;
            b_q      <= b_d;
            mm_q     <= mm_d;
            cnt_q    <= cnt_d;
            k_q      <= k_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            error_q  <= error_d;
            result_q <= result_d;
        end
    end

    assign bus.busy   = busy_q;
    assign bus.isDone = done_q;
    assign bus.result = result_q;
    assign bus.error  = error_q;
endmodule

// File: tb/tb_mod_exp_engine.sv
// Directed-vector bench for mod_exp_engine: a 16-bit instance for the table, handshake,
// reset and random cases, and a 64-bit instance for the full-width reference case.
module tb_mod_exp_engine;
    logic clk;
    logic reset;
    logic sel;
    int   checks;
    int   failures;

    mod_exp_engine_if #(.WIDTH(16), .EXP_WIDTH(16)) if_a ();
    mod_exp_engine_if #(.WIDTH(64), .EXP_WIDTH(64)) if_b ();

    mod_exp_engine #(.WIDTH(16), .EXP_WIDTH(16)) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (if_a.slave)
    );

    mod_exp_engine #(.WIDTH(64), .EXP_WIDTH(64)) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (if_b.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    wire        cur_busy   = sel ? if_b.busy   : if_a.busy;
    wire        cur_done   = sel ? if_b.isDone : if_a.isDone;
    wire        cur_error  = sel ? if_b.error  : if_a.error;
    wire [63:0] cur_result = sel ? if_b.result : {48'd0, if_a.result};

    typedef struct {
        logic [15:0] b;
        logic [15:0] e;
        logic [15:0] m;
        logic [15:0] r;
        logic        er;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] mulmod(logic [63:0] a, logic [63:0] b, logic [63:0] n);
        logic [127:0] p;
        p = {64'd0, a} * {64'd0, b};
        p = p % {64'd0, n};
        return p[63:0];
    endfunction

    function automatic logic [63:0] ref_modexp(logic [63:0] b, logic [63:0] e,
                                               logic [63:0] n, int ew);
        logic [63:0] r;
        logic [63:0] bb;
        if (n == 64'd0) return 64'd0;
        r  = 64'd1 % n;
        bb = b % n;
        for (int i = ew - 1; i >= 0; i--) begin
            r = mulmod(r, r, n);
            if (e[i]) r = mulmod(r, bb, n);
        end
        return r;
    endfunction

    function automatic int lat_model(logic [63:0] e, logic [63:0] m, int w, int ew);
        if (m == 64'd0) return 2;
        return 2 + w * (1 + ew + $countones(e));
    endfunction

    task automatic drive(input bit s, input logic [63:0] b, input logic [63:0] e,
                         input logic [63:0] m);
        if (s) begin
            if_b.base     = b;
            if_b.exponent = e;
            if_b.modulus  = m;
        end else begin
            if_a.base     = b[15:0];
            if_a.exponent = e[15:0];
            if_a.modulus  = m[15:0];
        end
    endtask

    task automatic set_start(input bit s, input logic v);
        if (s) if_b.start = v;
        else   if_a.start = v;
    endtask

    task automatic run_op(input bit s, input logic [63:0] b, input logic [63:0] e,
                          input logic [63:0] m, input bit perturb,
                          output logic [63:0] res, output logic err, output int lat);
        bit done;
        bit busy_ok;
        @(negedge clk);
        sel = s;
        drive(s, b, e, m);
        set_start(s, 1'b1);
        @(posedge clk);
        #1;
        set_start(s, 1'b0);
        chk("accept_flags", {cur_busy, cur_done, cur_error}, 3'b100);
        lat     = 0;
        done    = 1'b0;
        busy_ok = 1'b1;
        while (!done && lat < 10000) begin
            @(posedge clk);
            #1;
            lat++;
            if (cur_done) begin
                done = 1'b1;
                if (cur_busy) busy_ok = 1'b0;
            end else if (!cur_busy) begin
                busy_ok = 1'b0;
            end
            if (perturb && lat == 40) begin
                drive(s, 64'd9, 64'd7, 64'd11);
                set_start(s, 1'b1);
            end
            if (perturb && lat == 45) set_start(s, 1'b0);
        end
        chk("done_timeout", done, 1'b1);
        chk("busy_span", busy_ok, 1'b1);
        res = cur_result;
        err = cur_error;
    endtask

    logic [63:0] res;
    logic        err;
    int          lat;
    logic [63:0] rb, re, rm;

    initial begin
        checks   = 0;
        failures = 0;
        sel      = 1'b0;
        if_a.start = 1'b0; if_a.base = '0; if_a.exponent = '0; if_a.modulus = '0;
        if_b.start = 1'b0; if_b.base = '0; if_b.exponent = '0; if_b.modulus = '0;

        vecs[0]  = '{16'd5,     16'd3,     16'd13,    16'd8,   1'b0};
        vecs[1]  = '{16'd2,     16'd10,    16'd7,     16'd2,   1'b0};
        vecs[2]  = '{16'd100,   16'd2,     16'd7,     16'd4,   1'b0};
        vecs[3]  = '{16'd3,     16'd0,     16'd7,     16'd1,   1'b0};
        vecs[4]  = '{16'd3,     16'd0,     16'd1,     16'd0,   1'b0};
        vecs[5]  = '{16'd0,     16'd5,     16'd11,    16'd0,   1'b0};
        vecs[6]  = '{16'd9,     16'd4,     16'd0,     16'd0,   1'b1};
        vecs[7]  = '{16'd4,     16'd13,    16'd497,   16'd445, 1'b0};
        vecs[8]  = '{16'd65535, 16'd2,     16'd65534, 16'd1,   1'b0};
        vecs[9]  = '{16'd65535, 16'd65535, 16'd65535, 16'd0,   1'b0};
        vecs[10] = '{16'd10,    16'd1,     16'd65535, 16'd10,  1'b0};

        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_a", {if_a.busy, if_a.isDone, if_a.error, if_a.result}, 19'd0);
        chk("reset_b", {if_b.busy, if_b.isDone, if_b.error, if_b.result}, 67'd0);
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < 11; i++) begin
            run_op(1'b0, {48'd0, vecs[i].b}, {48'd0, vecs[i].e}, {48'd0, vecs[i].m},
                   1'b0, res, err, lat);
            chk($sformatf("vec%0d_result", i), res, {48'd0, vecs[i].r});
            chk($sformatf("vec%0d_error", i), err, vecs[i].er);
            chk($sformatf("vec%0d_latency", i), lat,
                lat_model({48'd0, vecs[i].e}, {48'd0, vecs[i].m}, 16, 16));
        end

        repeat (5) @(posedge clk);
        #1;
        chk("done_hold", {cur_done, cur_result}, {1'b1, 64'd10});

        // start pulses and operand changes mid-operation must not disturb the run
        run_op(1'b0, 64'd5, 64'd3, 64'd13, 1'b1, res, err, lat);
        chk("perturb_result", res, 64'd8);
        chk("perturb_latency", lat, 306);

        @(negedge clk);
        sel = 1'b0;
        drive(1'b0, 64'd2, 64'd10, 64'd7);
        if_a.start = 1'b1;
        @(posedge clk);
        #1;
        if_a.start = 1'b0;
        repeat (25) @(posedge clk);
        #1;
        chk("busy_before_abort", if_a.busy, 1'b1);
        #2;
        reset = 1'b0;
        #1;
        chk("abort_outputs", {if_a.busy, if_a.isDone, if_a.error, if_a.result}, 19'd0);
        @(negedge clk);
        reset = 1'b1;
        run_op(1'b0, 64'd2, 64'd10, 64'd7, 1'b0, res, err, lat);
        chk("restart_result", res, 64'd2);
        chk("restart_latency", lat, lat_model(64'd10, 64'd7, 16, 16));

        rb = 64'd2;
        re = 64'hFFFF_FFFF_FFFF_FFFF;
        rm = 64'hFFFF_FFFF_FFFF_FFC5;
        run_op(1'b1, rb, re, rm, 1'b0, res, err, lat);
        chk("w64_result", res, ref_modexp(rb, re, rm, 64));
        chk("w64_error", err, 1'b0);
        chk("w64_latency", lat, lat_model(re, rm, 64, 64));

        for (int i = 0; i < 80; i++) begin
            rb = {48'd0, 16'($urandom)};
            re = {48'd0, 16'($urandom)};
            rm = {48'd0, 16'($urandom_range(1, 65535))};
            run_op(1'b0, rb, re, rm, 1'b0, res, err, lat);
            chk($sformatf("rand%0d_result", i), res, ref_modexp(rb, re, rm, 16));
            chk($sformatf("rand%0d_latency", i), lat, lat_model(re, rm, 16, 16));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
